wb_mem_arbiter: RTL
===================

# wb_mem_arbiter

Two-master Wishbone round-robin arbiter that shares the single Tx/Rx data memory slave between the Ethernet MAC DMA master (port m0) and the testbench/host traffic master (port m1). The arbiter grants one master at a time for a whole bus cycle (`cyc` envelope) and multiplexes address, data, select and strobe toward the memory slave. It routes ack/err/rty back only to the granted master. A per-grant watchdog terminates stalled transfers with an error so a non-responding slave configuration cannot hang the MAC.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; `sel` width is DW/8.
- `TIMEOUT`, 8'd255, watchdog limit in cycles (legal 1..255); 8-bit counter.

Ports:
- `wb_clk_i`  in  1  single clock.
- `wb_rst_i`  in  1  reset; synchronous and active-high.
- `m0_cyc_o, m0_stb_o, m0_we_o`  in  1 each  MAC master control.
- `m0_adr_o`  in  AW. `m0_dat_o`  in  DW. `m0_sel_o`  in  DW/8.
- `m0_ack_i, m0_err_i, m0_rty_i`  out  1 each  termination to MAC master.
- `m0_dat_i`  out  DW  read data to MAC master.
- `m1_*`: the same set for the host master.
- `s_cyc, s_stb, s_we`  out  1 each  to memory slave.
- `s_adr`  out  AW. `s_dat_w`  out  DW. `s_sel`  out  DW/8.
- `s_ack, s_err, s_rty`  in  1 each  from memory slave.
- `s_dat_r`  in  DW  read data from slave.
- `gnt`  out  2  one-hot current grant; 2'b00 when idle.
- `timeout_o`  out  1  one-cycle pulse on watchdog fire.

## Operation
- FSM states: IDLE, G0, G1. `gnt` = {state==G1, state==G0}.
- Round-robin pointer `last` (1 bit), reset to 1, so m0 wins the first contention.
- IDLE: if only mN_cyc_o is high, go to GN. If both are high, grant the master != `last`. Otherwise stay in IDLE.
- Entering GN sets `last` to N.
- GN while mN_cyc_o is high: stay in GN. The grant is never revoked mid-cycle, including across multiple stb beats and retries.
- GN when mN_cyc_o is low:
  - If the other master's cyc is high, move directly to its grant.
  - Otherwise go to IDLE.
- Slave mux, combinational from state:
  - In GN, all s_* outputs equal mN_*.
  - In IDLE, all s_* outputs are 0.
- Termination routing:
  - mN_ack_i and mN_rty_i = s_ack/s_rty gated by (state==GN).
  - mN_err_i = (s_err OR wd_err) gated by (state==GN).
  - The ungranted master always sees 0 on ack/err/rty.
- mN_dat_i = s_dat_r for both masters, unconditionally. Data is valid only with the master's own ack.
- Watchdog, `wd_cnt` (8 bit):
  - Clears to 0 in IDLE, on any s_ack/s_err/s_rty, when granted stb is low, and on a grant change.
  - Otherwise increments each cycle.
  - When wd_cnt == TIMEOUT-1 with granted stb high and no slave termination, wd_err is asserted for that cycle. In that cycle s_stb is forced to 0, timeout_o pulses, and wd_cnt clears next edge.

## Timing
- Grant latency: 1 cycle. mN_cyc_o high at edge k (arbiter in IDLE) gives s_cyc at cycle k+1.
- Handoff latency: 0 idle cycles. The release cycle shows s_cyc=0; the other master's cyc/stb appear on s_* the next cycle.
- Termination path s_ack → mN_ack_i is combinational (0 cycles), so a zero-wait slave completes one beat per cycle.
- Reset (synchronous, any state, including mid-transfer):
  - Next edge: state IDLE, last=1, wd_cnt=0.
  - Outputs: s_* all 0, gnt=0, all mN_ack/err/rty=0, timeout_o=0.
  - mN_dat_i follows s_dat_r.
- Simultaneous events:
  - Slave termination in the same cycle wd_cnt hits its limit: the slave response wins; no wd_err, no timeout_o.
  - Both masters request in the same IDLE cycle: the `last` rule decides.
- TIMEOUT=1: wd_err fires on the first stalled stb cycle.

## Test plan
- Single m0 write, adr=0x10, dat=0xDEADBEEF, sel=4'hF, slave ack on 1st stb cycle → gnt=01 one cycle after cyc, s_* mirror m0, m0_ack_i=1, m1_ack_i=0 throughout.
- m0 and m1 assert cyc the same cycle after reset → m0 granted first (gnt=01). On m0 release, gnt=10 the next cycle with no IDLE gap. Repeat contention → m1 then m0 alternation.
- m1 holds cyc for a 4-beat burst while m0 requests → gnt stays 10 for all 4 acks; m0 sees no ack/err/rty; m0 is granted after m1 drops cyc.
- TIMEOUT=8, slave never responds to an m0 stb → m0_err_i and timeout_o high exactly on the 8th stb cycle, s_stb=0 that cycle, wd_cnt back to 0.
- Slave ack coincides with the 8th stalled cycle → m0_ack_i=1, m0_err_i=0, timeout_o=0.
- wb_rst_i asserted mid-burst in G1 → next cycle gnt=00, s_cyc=0, all terminations 0. First contention after reset grants m0.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - two-master round-robin Wishbone arbiter with per-grant watchdog
module wb_mem_arbiter #(
  parameter int         AW      = 32,
  parameter int         DW      = 32,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  // MAC DMA master
  input  logic            m0_cyc_o,
  input  logic            m0_stb_o,
  input  logic            m0_we_o,
  input  logic [AW-1:0]   m0_adr_o,
  input  logic [DW-1:0]   m0_dat_o,
  input  logic [DW/8-1:0] m0_sel_o,
  output logic            m0_ack_i,
  output logic            m0_err_i,
  output logic            m0_rty_i,
  output logic [DW-1:0]   m0_dat_i,
  // host traffic master
  input  logic            m1_cyc_o,
  input  logic            m1_stb_o,
  input  logic            m1_we_o,
  input  logic [AW-1:0]   m1_adr_o,
  input  logic [DW-1:0]   m1_dat_o,
  input  logic [DW/8-1:0] m1_sel_o,
  output logic            m1_ack_i,
  output logic            m1_err_i,
  output logic            m1_rty_i,
  output logic [DW-1:0]   m1_dat_i,
  // memory slave
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_w,
  output logic [DW/8-1:0] s_sel,
  input  logic            s_ack,
  input  logic            s_err,
  input  logic            s_rty,
  input  logic [DW-1:0]   s_dat_r,
  output logic [1:0]      gnt,
  output logic            timeout_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  localparam logic [7:0] WD_LIMIT = TIMEOUT - 8'd1;

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] wd_cnt, wd_cnt_nxt;
  logic       gnt_stb;
  logic       s_term;
  logic       wd_err;

  // State, round-robin pointer and watchdog registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      last   <= 1'b1;
      wd_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      wd_cnt <= wd_cnt_nxt;
    end
  end

  // Grant selection: hold for the whole cyc envelope, hand off directly on release
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_o && m1_cyc_o) state_nxt = last ? G0 : G1;
        else if (m0_cyc_o)        state_nxt = G0;
        else if (m1_cyc_o)        state_nxt = G1;
      end
      G0: begin
        if (!m0_cyc_o) state_nxt = m1_cyc_o ? G1 : IDLE;
      end
      G1: begin
        if (!m1_cyc_o) state_nxt = m0_cyc_o ? G0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) begin
      if (state_nxt == G0) last_nxt = 1'b0;
      if (state_nxt == G1) last_nxt = 1'b1;
    end
  end

  // Watchdog: counts consecutive unanswered strobe cycles of the current grant
  always_comb begin
    gnt_stb    = ((state == G0) && m0_stb_o) || ((state == G1) && m1_stb_o);
    s_term     = s_ack || s_err || s_rty;
    wd_err     = gnt_stb && !s_term && (wd_cnt == WD_LIMIT);
    wd_cnt_nxt = wd_cnt + 8'd1;
    if (!gnt_stb || s_term || wd_err || (state_nxt != state)) wd_cnt_nxt = 8'd0;
  end

  // Slave mux and termination routing, driven purely by the current grant
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_w  = '0;
    s_sel    = '0;
    m0_ack_i = 1'b0;
    m0_err_i = 1'b0;
    m0_rty_i = 1'b0;
    m1_ack_i = 1'b0;
    m1_err_i = 1'b0;
    m1_rty_i = 1'b0;
    case (state)
      G0: begin
        s_cyc    = m0_cyc_o;
        s_stb    = m0_stb_o && !wd_err;
        s_we     = m0_we_o;
        s_adr    = m0_adr_o;
        s_dat_w  = m0_dat_o;
        s_sel    = m0_sel_o;
        m0_ack_i = s_ack;
        m0_err_i = s_err || wd_err;
        m0_rty_i = s_rty;
      end
      G1: begin
        s_cyc    = m1_cyc_o;
        s_stb    = m1_stb_o && !wd_err;
        s_we     = m1_we_o;
        s_adr    = m1_adr_o;
        s_dat_w  = m1_dat_o;
        s_sel    = m1_sel_o;
        m1_ack_i = s_ack;
        m1_err_i = s_err || wd_err;
        m1_rty_i = s_rty;
      end
      default: ;
    endcase
  end

  assign m0_dat_i  = s_dat_r;
  assign m1_dat_i  = s_dat_r;
  assign gnt       = {state == G1, state == G0};
  assign timeout_o = wd_err;

endmodule
